// File: rtl/i2s_adc_receiver.sv
// Stereo I2S ADC front end: drives sclk_out, oversamples bclk/lrclk/dout and presents L/R frames on stb/ack.
// Define I2S_LEFT_JUSTIFIED_EN to receive left-justified data instead of standard I2S.
module i2s_adc_receiver #(
    parameter int DATA_WIDTH = 24,
    parameter int SCLK_DIV   = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bclk_in,
    input  logic                  lrclk_in,
    input  logic                  dout_in,
    output logic                  sclk_out,
    output logic [DATA_WIDTH-1:0] left_out,
    output logic [DATA_WIDTH-1:0] right_out,
    output logic                  sample_stb_out,
    input  logic                  sample_ack_in,
    output logic                  overrun_out
);
    localparam int CW   = $clog2(DATA_WIDTH) + 1;
    localparam int HALF = SCLK_DIV / 2;
    localparam int DIVW = $clog2(HALF + 1);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        LEFT      = 2'd1,
        RIGHT     = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [DIVW-1:0]         div_cnt;
    logic [2:0]              bclk_pipe;
    logic [1:0]              lrclk_pipe;
    logic [1:0]              dout_pipe;
    logic                    lr_prev;
    logic                    bclk_rise;
    logic                    lr_fall;
    logic                    lr_rise;
    logic                    dout_bit;
    logic                    start_word;
    logic                    close_left;
    logic                    close_right;
    logic                    capture;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_sat;
    logic [CW-1:0]           open_cnt;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [DATA_WIDTH-1:0]   word_with_bit;
    logic [DATA_WIDTH-1:0]   closed_word;
    logic [DATA_WIDTH-1:0]   open_word;
    logic [DATA_WIDTH-1:0]   left_hold;
    logic [DATA_WIDTH-1:0]   right_hold;
    logic                    frame_pend;

    // ADC system clock, free-running divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            sclk_out <= 1'b0;
        end else if (div_cnt == DIVW'(HALF - 1)) begin
            div_cnt  <= '0;
            sclk_out <= ~sclk_out;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // dout and lrclk share the bclk synchroniser depth so they line up with bclk_rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_pipe  <= '0;
            lrclk_pipe <= '0;
            dout_pipe  <= '0;
            lr_prev    <= 1'b0;
        end else begin
            bclk_pipe  <= {bclk_pipe[1:0], bclk_in};
            lrclk_pipe <= {lrclk_pipe[0], lrclk_in};
            dout_pipe  <= {dout_pipe[0], dout_in};
            if (bclk_rise) begin
                lr_prev <= lrclk_pipe[1];
            end
        end
    end

    assign bclk_rise = bclk_pipe[1] & ~bclk_pipe[2];
    assign dout_bit  = dout_pipe[1];
    assign lr_fall   = bclk_rise & lr_prev & ~lrclk_pipe[1];
    assign lr_rise   = bclk_rise & ~lr_prev & lrclk_pipe[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_SYNC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start_word  = 1'b0;
        close_left  = 1'b0;
        close_right = 1'b0;
        capture     = 1'b0;
        case (state)
            WAIT_SYNC: begin
                if (lr_fall) begin
                    state_next = LEFT;
                    start_word = 1'b1;
                end
            end
            LEFT: begin
                if (lr_rise) begin
                    state_next = RIGHT;
                    close_left = 1'b1;
                end else if (bclk_rise) begin
                    capture = 1'b1;
                end
            end
            RIGHT: begin
                if (lr_fall) begin
                    state_next  = LEFT;
                    close_right = 1'b1;
                end else if (bclk_rise) begin
                    capture = 1'b1;
                end
            end
            default: state_next = WAIT_SYNC;
        endcase
    end

    // Bits past DATA_WIDTH fall off; cnt saturates so they never wrap onto the MSBs
    always_comb begin
        word_with_bit = shift_reg;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (cnt == CW'(DATA_WIDTH - 1 - i)) begin
                word_with_bit[i] = dout_bit;
            end
        end
    end

    assign cnt_sat = (cnt == CW'(DATA_WIDTH)) ? cnt : cnt + 1'b1;

`ifdef I2S_LEFT_JUSTIFIED_EN
    // The lrclk-edge bit already belongs to the new word: it becomes its MSB
    always_comb begin
        open_word                 = '0;
        open_word[DATA_WIDTH-1]   = dout_bit;
    end
    assign closed_word = shift_reg;
    assign open_cnt    = CW'(1);
`else
    // Standard I2S: the lrclk-edge bit is the LSB of the word being closed
    assign open_word   = '0;
    assign closed_word = word_with_bit;
    assign open_cnt    = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg  <= '0;
            cnt        <= '0;
            left_hold  <= '0;
            right_hold <= '0;
            frame_pend <= 1'b0;
        end else begin
            frame_pend <= close_right;
            if (start_word) begin
                shift_reg <= open_word;
                cnt       <= open_cnt;
            end else if (close_left) begin
                left_hold <= closed_word;
                shift_reg <= open_word;
                cnt       <= open_cnt;
            end else if (close_right) begin
                right_hold <= closed_word;
                shift_reg  <= open_word;
                cnt        <= open_cnt;
            end else if (capture) begin
                shift_reg <= word_with_bit;
                cnt       <= cnt_sat;
            end
        end
    end

    // Handshake: a frame transfers on any clk edge with sample_stb_out & sample_ack_in; while stb is high
    // left_out/right_out do not change. A frame finishing while an unacked one is held is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_out       <= '0;
            right_out      <= '0;
            sample_stb_out <= 1'b0;
            overrun_out    <= 1'b0;
        end else begin
            overrun_out <= 1'b0;
            if (frame_pend) begin
                if (!sample_stb_out || sample_ack_in) begin
                    left_out       <= left_hold;
                    right_out      <= right_hold;
                    sample_stb_out <= 1'b1;
                end else begin
                    overrun_out <= 1'b1;
                end
            end else if (sample_stb_out && sample_ack_in) begin
                sample_stb_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Directed bench for i2s_adc_receiver: reset/sclk, I2S frames, partial-start, overrun and short words.
`timescale 1ns/1ps
module tb_i2s_adc_receiver;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bclk = 1'b0;
    logic          lrclk = 1'b1;
    logic          dout = 1'b0;
    logic          ack = 1'b0;
    logic          sclk;
    logic          stb;
    logic          ovr;
    logic [DW-1:0] left;
    logic [DW-1:0] right;

    int   n_vec = 0;
    int   n_err = 0;
    int   ovr_cnt = 0;
    int   half_ns = 160;
    logic carry = 1'b0;

    i2s_adc_receiver #(.DATA_WIDTH(DW), .SCLK_DIV(12)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bclk_in        (bclk),
        .lrclk_in       (lrclk),
        .dout_in        (dout),
        .sclk_out       (sclk),
        .left_out       (left),
        .right_out      (right),
        .sample_stb_out (stb),
        .sample_ack_in  (ack),
        .overrun_out    (ovr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ovr === 1'b1) ovr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic lr, input logic d);
        bclk = 1'b0; lrclk = lr; dout = d;
        #(half_ns);
        bclk = 1'b1;
        #(half_ns);
    endtask

    // One channel slot; the first bclk carries the lrclk change
    task automatic send_slot(input logic lr, input logic [31:0] val, input int width,
                             input int slot, input bit chk);
        logic [31:0] w;
        logic        first;
        w = val << (slot - width);
`ifdef I2S_LEFT_JUSTIFIED_EN
        first = w[slot-1];
`else
        first = carry;
`endif
        bclk = 1'b0; lrclk = lr; dout = first;
        #(half_ns);
        if (chk) begin
            @(negedge clk);
            bclk = 1'b1;
            repeat (3) @(posedge clk);
            #1 check("stb_latency_early", stb, 0);
            @(posedge clk);
            #1 check("stb_latency", stb, 1);
        end else begin
            bclk = 1'b1;
        end
        #(half_ns);
`ifdef I2S_LEFT_JUSTIFIED_EN
        for (int i = slot - 2; i >= 0; i--) send_bit(lr, w[i]);
`else
        for (int i = slot - 1; i >= 1; i--) send_bit(lr, w[i]);
        carry = w[0];
`endif
    endtask

    task automatic do_ack(input string tag);
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk);
        #1 check(tag, stb, 0);
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        // reset state and sclk waveform
        repeat (3) @(posedge clk);
        #1;
        check("rst_sclk", sclk, 0);
        check("rst_left", left, 0);
        check("rst_right", right, 0);
        check("rst_stb", stb, 0);
        check("rst_ovr", ovr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            @(posedge clk);
            #1 check("sclk_wave", sclk, (n / 6) % 2);
        end

        // I2S frame at slow bclk, 32 bclk per channel
        half_ns = 160;
        carry = 1'b0;
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_slot(1'b0, 32'h123456, 24, 32, 1'b0);
        send_slot(1'b1, 32'hABCDEF, 24, 32, 1'b0);
        check("no_frame_yet", stb, 0);
        send_slot(1'b0, 32'h654321, 24, 32, 1'b1);
        check("f1_left", left, 32'h123456);
        check("f1_right", right, 32'hABCDEF);
        check("f1_ovr", ovr_cnt, 0);
        do_ack("f1_ack");
        @(negedge clk);
        ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("stray_ack", stb, 0);
        ack = 1'b0;

        // reset mid-stream, restart in the middle of a right word
        half_ns = 40;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst2_left", left, 0);
        check("rst2_right", right, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) send_bit(1'b1, 1'b1);
        carry = 1'b1;
        send_slot(1'b0, 32'h0F0F0F, 24, 32, 1'b0);
        send_slot(1'b1, 32'h5A5A5A, 24, 32, 1'b0);
        check("no_partial", stb, 0);
        send_slot(1'b0, 32'h3C3C3C, 24, 32, 1'b0);
        check("p1_stb", stb, 1);
        check("p1_left", left, 32'h0F0F0F);
        check("p1_right", right, 32'h5A5A5A);

        // second frame with no ack is dropped
        send_slot(1'b1, 32'hC3C3C3, 24, 32, 1'b0);
        send_slot(1'b0, 32'h777777, 24, 32, 1'b0);
        check("ovr_once", ovr_cnt, 1);
        check("hold_stb", stb, 1);
        check("hold_left", left, 32'h0F0F0F);
        check("hold_right", right, 32'h5A5A5A);
        do_ack("ovr_ack");
        send_slot(1'b1, 32'h888888, 24, 32, 1'b0);
        send_slot(1'b0, 32'h246810, 24, 32, 1'b0);
        check("f3_stb", stb, 1);
        check("f3_left", left, 32'h777777);
        check("f3_right", right, 32'h888888);
        do_ack("f3_ack");

        // switch to 16 bclk per channel
        send_slot(1'b1, 32'h135790, 24, 32, 1'b0);
        send_slot(1'b0, 32'h8001, 16, 16, 1'b0);
        check("f4_left", left, 32'h246810);
        check("f4_right", right, 32'h135790);
        do_ack("f4_ack");
        send_slot(1'b1, 32'h7FFE, 16, 16, 1'b0);
        send_slot(1'b0, 32'h000000, 24, 32, 1'b0);
        check("short_stb", stb, 1);
        check("short_left", left, 32'h800100);
        check("short_right", right, 32'h7FFE00);
        do_ack("short_ack");
        check("ovr_total", ovr_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
